// File: rtl/eightbit_io_pkg.sv
// Shared definitions for the button poller: FSM states, event layout, bus widths.
package eightbit_io_pkg;

    localparam int BTN_COUNT = 4;
    localparam int BTN_IDX_W = 2;
    localparam int ADDR_W    = 5;
    localparam int EVT_W     = 8;

    // Event byte layout: press flag on top, button index in the low bits.
    localparam int EVT_PRESS_BIT = 7;
    localparam int EVT_IDX_MSB   = 1;
    localparam int EVT_IDX_LSB   = 0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_ADDR = 3'd2,
        ST_SAMP = 3'd3,
        ST_DONE = 3'd4
    } poll_state_t;

    // Build an event byte; all bits outside the press flag and index stay 0.
    function automatic logic [EVT_W-1:0] make_event(input logic press,
                                                    input logic [BTN_IDX_W-1:0] idx);
        logic [EVT_W-1:0] e;
        e = '0;
        e[EVT_PRESS_BIT] = press;
        e[EVT_IDX_MSB:EVT_IDX_LSB] = idx;
        return e;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Small synchronous FIFO with a registered head entry and drop reporting.
module event_fifo
    import eightbit_io_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [EVT_W-1:0] din,
    input  logic             pop,
    output logic [EVT_W-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [EVT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_next;
    logic [CW-1:0]    count;
    logic             pop_eff;
    logic             push_eff;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    // A pop on an empty FIFO is ignored; a push into a full FIFO only lands
    // when a pop frees the head slot in the same cycle.
    assign pop_eff  = pop && !empty;
    assign push_eff = push && (!full || pop_eff);
    assign drop     = push && full && !pop_eff;
    assign rd_next  = rd_ptr + 1'b1;

    // Storage array; no reset needed since only valid entries are ever read.
    always_ff @(posedge clk) begin
        if (push_eff)
            mem[wr_ptr] <= din;
    end

    // Pointers, occupancy and the registered head entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (push_eff)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_eff)
                rd_ptr <= rd_next;
            count <= count + CW'(push_eff) - CW'(pop_eff);
            // Head only moves on a pop or on a push into an empty FIFO.
            if (pop_eff) begin
                if (count == CW'(1))
                    dout <= push_eff ? din : '0;
                else
                    dout <= mem[rd_next];
            end else if (push_eff && empty) begin
                dout <= din;
            end
        end
    end

endmodule

// File: rtl/button_poll_controller.sv
// Bus-mastering poller: reads the 4 buttons each round, debounces them and
// queues press/release events into a FIFO for the CPU.
module button_poll_controller
    import eightbit_io_pkg::*;
#(
    parameter int POLL_PERIOD = 1000,
    parameter int DEBOUNCE    = 3,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [ADDR_W-1:0] dev_address,
    output logic              dev_enable,
    output logic              dev_mode,
    input  logic [7:0]        dev_data,
    output logic              evt_valid,
    output logic [EVT_W-1:0]  evt_data,
    input  logic              evt_pop,
    output logic [BTN_COUNT-1:0] stable_state,
    output logic              overflow,
    input  logic              overflow_clr
);

    localparam int TW    = $clog2(POLL_PERIOD);
    localparam int CNT_W = 4;

    poll_state_t                          state;
    logic [BTN_IDX_W-1:0]                 idx;
    logic [TW-1:0]                        timer;
    logic                                 tick;
    logic [BTN_COUNT-1:0][CNT_W-1:0]      cnt;
    logic [BTN_COUNT-1:0]                 sel;
    logic [BTN_COUNT-1:0]                 differ;
    logic [BTN_COUNT-1:0]                 flip;
    logic                                 sample_now;
    logic                                 push;
    logic [EVT_W-1:0]                     push_evt;
    logic                                 fifo_full;
    logic                                 fifo_empty;
    logic                                 fifo_drop;
    logic [6:0]                           unused_dev_data;

    // Only bit 0 of the device data carries the button level.
    assign unused_dev_data = dev_data[7:1];

    assign tick = (timer == TW'(POLL_PERIOD - 1));

    // Free-running poll timer; wraps every POLL_PERIOD cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timer <= '0;
        else if (tick)
            timer <= '0;
        else
            timer <= timer + 1'b1;
    end

    // Poll sequencer with registered bus outputs. Losing the grant mid-round
    // abandons the round; a tick arriving outside IDLE is simply dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            bus_req     <= 1'b0;
            dev_enable  <= 1'b0;
            dev_mode    <= 1'b0;
            dev_address <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        state   <= ST_REQ;
                        bus_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (bus_gnt) begin
                        state       <= ST_ADDR;
                        idx         <= '0;
                        dev_enable  <= 1'b1;
                        dev_mode    <= 1'b1;
                        dev_address <= '0;
                    end
                end
                ST_ADDR: begin
                    if (!bus_gnt) begin
                        state       <= ST_IDLE;
                        bus_req     <= 1'b0;
                        dev_enable  <= 1'b0;
                        dev_mode    <= 1'b0;
                        dev_address <= '0;
                    end else begin
                        state <= ST_SAMP;
                    end
                end
                ST_SAMP: begin
                    if (!bus_gnt || idx == BTN_IDX_W'(BTN_COUNT - 1)) begin
                        state       <= bus_gnt ? ST_DONE : ST_IDLE;
                        bus_req     <= 1'b0;
                        dev_enable  <= 1'b0;
                        dev_mode    <= 1'b0;
                        dev_address <= '0;
                    end else begin
                        state       <= ST_ADDR;
                        idx         <= idx + 1'b1;
                        dev_address <= ADDR_W'(idx + 1'b1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The sample is taken at the end of a SAMP cycle, and only while granted.
    assign sample_now = (state == ST_SAMP) && bus_gnt;

    // Per-button debounce decode: which button is sampled and whether it flips.
    always_comb begin
        sel    = '0;
        differ = '0;
        flip   = '0;
        for (int b = 0; b < BTN_COUNT; b++) begin
            sel[b]    = sample_now && (idx == BTN_IDX_W'(b));
            differ[b] = dev_data[0] ^ stable_state[b];
            flip[b]   = sel[b] && differ[b] && (cnt[b] == CNT_W'(DEBOUNCE - 1));
        end
    end

    // Debounce counters and stable levels; a matching sample resets the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            stable_state <= '0;
        end else begin
            for (int b = 0; b < BTN_COUNT; b++) begin
                if (sel[b]) begin
                    if (!differ[b]) begin
                        cnt[b] <= '0;
                    end else if (flip[b]) begin
                        cnt[b]          <= '0;
                        stable_state[b] <= ~stable_state[b];
                    end else begin
                        cnt[b] <= cnt[b] + 1'b1;
                    end
                end
            end
        end
    end

    // Only one button is sampled per cycle, so at most one flip can occur.
    assign push     = |flip;
    assign push_evt = make_event(~stable_state[idx], idx);

    event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_evt),
        .pop   (evt_pop),
        .dout  (evt_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    assign evt_valid = ~fifo_empty;

    // Sticky overflow; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overflow <= 1'b0;
        else if (fifo_drop)
            overflow <= 1'b1;
        else if (overflow_clr)
            overflow <= 1'b0;
    end

endmodule

// File: tb/tb_button_poll_controller.sv
// Directed bench for button_poll_controller with a simple button device model.
module tb_button_poll_controller;

    localparam int PP = 16;
    localparam int DB = 3;
    localparam int FD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bus_gnt = 1'b1;
    logic       evt_pop = 1'b0;
    logic       overflow_clr = 1'b0;
    logic [7:0] dev_data = 8'd0;
    logic [3:0] btn = 4'd0;

    logic       bus_req;
    logic [4:0] dev_address;
    logic       dev_enable;
    logic       dev_mode;
    logic       evt_valid;
    logic [7:0] evt_data;
    logic [3:0] stable_state;
    logic       overflow;

    int checks = 0;
    int failures = 0;

    button_poll_controller #(
        .POLL_PERIOD (PP),
        .DEBOUNCE    (DB),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus_req      (bus_req),
        .bus_gnt      (bus_gnt),
        .dev_address  (dev_address),
        .dev_enable   (dev_enable),
        .dev_mode     (dev_mode),
        .dev_data     (dev_data),
        .evt_valid    (evt_valid),
        .evt_data     (evt_data),
        .evt_pop      (evt_pop),
        .stable_state (stable_state),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    // Button device: latches the addressed button level on the falling edge.
    always @(negedge clk) begin
        if (dev_enable)
            dev_data = {7'd0, btn[dev_address[1:0]]};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_pop();
        evt_pop = 1'b1;
        step();
        evt_pop = 1'b0;
    endtask

    // Wait for one complete poll round (bus_req rise then fall), bounded.
    task automatic do_round();
        int n;
        n = 0;
        while (bus_req !== 1'b1 && n < 64) begin step(); n++; end
        checks++;
        if (bus_req !== 1'b1) begin
            failures++;
            $display("FAIL round_start: bus_req=%b expected 1 within 64 cycles", bus_req);
        end
        n = 0;
        while (bus_req !== 1'b0 && n < 64) begin step(); n++; end
        checks++;
        if (bus_req !== 1'b0) begin
            failures++;
            $display("FAIL round_end: bus_req=%b expected 0 within 64 cycles", bus_req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus_req, dev_enable, dev_mode, dev_address} !== 8'd0) begin
            failures++;
            $display("FAIL reset_bus: got %b expected 0", {bus_req, dev_enable, dev_mode, dev_address});
        end
        checks++;
        if ({evt_valid, evt_data} !== 9'd0) begin
            failures++;
            $display("FAIL reset_evt: valid=%b data=%h expected 0/00", evt_valid, evt_data);
        end
        checks++;
        if ({stable_state, overflow} !== 5'd0) begin
            failures++;
            $display("FAIL reset_state: stable=%b overflow=%b expected 0", stable_state, overflow);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_poll_sequence();
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 15) begin
                checks++;
                if (bus_req !== 1'b0) begin
                    failures++;
                    $display("FAIL req_early: edge %0d bus_req=%b expected 0", k, bus_req);
                end
            end
        end
        checks++;
        if ({bus_req, dev_enable} !== 2'b10) begin
            failures++;
            $display("FAIL req_rise: req/en=%b expected 10", {bus_req, dev_enable});
        end
        for (int j = 0; j < 8; j++) begin
            step();
            checks++;
            if ({bus_req, dev_enable, dev_mode, dev_address} !== {3'b111, 5'(j / 2)}) begin
                failures++;
                $display("FAIL poll_seq%0d: req/en/mode/addr=%b expected %b", j,
                         {bus_req, dev_enable, dev_mode, dev_address}, {3'b111, 5'(j / 2)});
            end
        end
        step();
        checks++;
        if ({bus_req, dev_enable, dev_mode, dev_address} !== 8'd0) begin
            failures++;
            $display("FAIL done_idle: got %b expected 0", {bus_req, dev_enable, dev_mode, dev_address});
        end
        checks++;
        if (evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL no_evt_first: evt_valid=%b expected 0", evt_valid);
        end
    endtask

    task automatic test_press_release();
        btn = 4'b0100;
        do_round();
        do_round();
        checks++;
        if ({evt_valid, stable_state} !== 5'b0_0000) begin
            failures++;
            $display("FAIL press_early: valid=%b stable=%b expected 0/0000", evt_valid, stable_state);
        end
        do_round();
        checks++;
        if ({evt_valid, evt_data, stable_state} !== {1'b1, 8'h82, 4'b0100}) begin
            failures++;
            $display("FAIL press_evt: valid=%b data=%h stable=%b expected 1/82/0100",
                     evt_valid, evt_data, stable_state);
        end
        do_pop();
        checks++;
        if (evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL press_pop: evt_valid=%b expected 0", evt_valid);
        end
        btn = 4'b0000;
        repeat (3) do_round();
        checks++;
        if ({evt_valid, evt_data, stable_state} !== {1'b1, 8'h02, 4'b0000}) begin
            failures++;
            $display("FAIL release_evt: valid=%b data=%h stable=%b expected 1/02/0000",
                     evt_valid, evt_data, stable_state);
        end
        do_pop();
    endtask

    task automatic test_toggle();
        for (int r = 0; r < 6; r++) begin
            btn[1] = (r % 2 == 0);
            do_round();
        end
        checks++;
        if ({evt_valid, stable_state} !== 5'b0_0000) begin
            failures++;
            $display("FAIL toggle: valid=%b stable=%b expected 0/0000", evt_valid, stable_state);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_q [4];
        int n;
        exp_q = '{8'h81, 8'h82, 8'h83, 8'h03};
        btn = 4'b1111;
        repeat (3) do_round();
        checks++;
        if ({evt_valid, evt_data, overflow, stable_state} !== {1'b1, 8'h80, 1'b0, 4'b1111}) begin
            failures++;
            $display("FAIL fifo_fill: valid=%b data=%h ovf=%b stable=%b expected 1/80/0/1111",
                     evt_valid, evt_data, overflow, stable_state);
        end
        btn = 4'b1110;
        repeat (3) do_round();
        checks++;
        if ({overflow, evt_data, stable_state} !== {1'b1, 8'h80, 4'b1110}) begin
            failures++;
            $display("FAIL fifo_drop: ovf=%b data=%h stable=%b expected 1/80/1110",
                     overflow, evt_data, stable_state);
        end
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clr: overflow=%b expected 0", overflow);
        end
        // Release button 3; its third sample coincides with a pop while full.
        btn = 4'b0110;
        repeat (2) do_round();
        n = 0;
        while (!(dev_enable === 1'b1 && dev_address === 5'd3) && n < 64) begin step(); n++; end
        checks++;
        if (!(dev_enable === 1'b1 && dev_address === 5'd3)) begin
            failures++;
            $display("FAIL find_addr3: en=%b addr=%0d expected 1/3", dev_enable, dev_address);
        end
        step();
        evt_pop = 1'b1;
        step();
        evt_pop = 1'b0;
        checks++;
        if ({overflow, evt_data, stable_state} !== {1'b0, 8'h81, 4'b0110}) begin
            failures++;
            $display("FAIL pop_push_full: ovf=%b data=%h stable=%b expected 0/81/0110",
                     overflow, evt_data, stable_state);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({evt_valid, evt_data} !== {1'b1, exp_q[i]}) begin
                failures++;
                $display("FAIL drain%0d: valid=%b data=%h expected 1/%h", i, evt_valid, evt_data, exp_q[i]);
            end
            do_pop();
        end
        checks++;
        if (evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty: evt_valid=%b expected 0", evt_valid);
        end
    endtask

    task automatic test_grant();
        int  n;
        logic saw_en;
        logic saw_drop;
        // Buttons 2 and 3 differ from their stable levels (1 and 0).
        btn = 4'b1010;
        do_round();
        bus_gnt = 1'b0;
        n = 0;
        while (bus_req !== 1'b1 && n < 64) begin step(); n++; end
        checks++;
        if (bus_req !== 1'b1) begin
            failures++;
            $display("FAIL gnt_req: bus_req=%b expected 1", bus_req);
        end
        saw_en = 1'b0;
        saw_drop = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            saw_en   = saw_en | dev_enable;
            saw_drop = saw_drop | ~bus_req;
        end
        checks++;
        if ({saw_en, saw_drop} !== 2'b00) begin
            failures++;
            $display("FAIL gnt_wait: saw_en/saw_drop=%b expected 00", {saw_en, saw_drop});
        end
        bus_gnt = 1'b1;
        step();
        checks++;
        if ({dev_enable, dev_address} !== 6'b1_00000) begin
            failures++;
            $display("FAIL gnt_first_en: en/addr=%b expected 1_00000", {dev_enable, dev_address});
        end
        repeat (8) step();
        checks++;
        if (bus_req !== 1'b0) begin
            failures++;
            $display("FAIL gnt_done: bus_req=%b expected 0", bus_req);
        end
        repeat (2) step();
        checks++;
        if (bus_req !== 1'b0) begin
            failures++;
            $display("FAIL tick_discard: bus_req=%b expected 0 (no queued tick)", bus_req);
        end
        step();
        checks++;
        if (bus_req !== 1'b1) begin
            failures++;
            $display("FAIL next_tick: bus_req=%b expected 1", bus_req);
        end
        repeat (4) step();
        checks++;
        if ({dev_enable, dev_address} !== 6'b1_00001) begin
            failures++;
            $display("FAIL samp1_pos: en/addr=%b expected 1_00001", {dev_enable, dev_address});
        end
        bus_gnt = 1'b0;
        step();
        checks++;
        if ({bus_req, dev_enable} !== 2'b00) begin
            failures++;
            $display("FAIL abort: req/en=%b expected 00", {bus_req, dev_enable});
        end
        bus_gnt = 1'b1;
        checks++;
        if ({evt_valid, stable_state} !== 5'b0_0110) begin
            failures++;
            $display("FAIL abort_keep: valid=%b stable=%b expected 0/0110", evt_valid, stable_state);
        end
        do_round();
        checks++;
        if ({evt_valid, evt_data, stable_state} !== {1'b1, 8'h02, 4'b1010}) begin
            failures++;
            $display("FAIL after_abort: valid=%b data=%h stable=%b expected 1/02/1010",
                     evt_valid, evt_data, stable_state);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        while (!(dev_enable === 1'b1 && dev_address === 5'd2) && n < 64) begin step(); n++; end
        checks++;
        if (!(dev_enable === 1'b1 && dev_address === 5'd2)) begin
            failures++;
            $display("FAIL find_addr2: en=%b addr=%0d expected 1/2", dev_enable, dev_address);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus_req, dev_enable, dev_mode, dev_address} !== 8'd0) begin
            failures++;
            $display("FAIL rst_mid_bus: got %b expected 0", {bus_req, dev_enable, dev_mode, dev_address});
        end
        checks++;
        if ({evt_valid, evt_data, stable_state} !== 13'd0) begin
            failures++;
            $display("FAIL rst_mid_state: valid=%b data=%h stable=%b expected 0/00/0000",
                     evt_valid, evt_data, stable_state);
        end
        btn = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        do_round();
        checks++;
        if ({evt_valid, stable_state} !== 5'd0) begin
            failures++;
            $display("FAIL post_rst_round: valid=%b stable=%b expected 0/0000", evt_valid, stable_state);
        end
    endtask

    initial begin
        test_reset();
        test_poll_sequence();
        test_press_release();
        test_toggle();
        test_overflow();
        test_grant();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
